iq_frame_fifo: RTL

- Buffers 13-bit I/Q samples from signal_gen and frames them into the 32-bit words that lvds_trx serialises.
- Sits between signal_gen and lvds_trx, on the slow clock domain.
- Releases one framed word per word-load strobe from the serialiser (the tx_done rising edge).
- Handles prefill, filler words on underrun, and the end-of-message marker word.

---
 rtl/iq_frame_fifo.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/iq_frame_fifo.sv
// -----------------------------------------------------------------------------
// iq_frame_fifo
//
// Purpose:
//   Buffers 13-bit I/Q sample pairs from signal_gen and frames them into the
//   32-bit words that lvds_trx serialises. One word is presented per word_req
//   strobe (the serialiser has just loaded tx_data). Streaming starts once the
//   FIFO is prefilled, or once a complete message (last flag) is queued. When
//   the FIFO runs dry, filler words go out and the sticky underrun flag is set.
//   After the final sample of a message, an end-of-message marker word goes out.
//
// Ports:
//   clk             slow clock (slowclk from lvds_trx)
//   reset           asynchronous, active-high, clears all state
//   s_valid         sample valid from signal_gen
//   s_ready         FIFO can accept a sample this cycle
//   s_i, s_q        13-bit two's complement I and Q samples
//   s_last          marks the final sample of the message
//   word_req        single-cycle strobe: present the next framed word
//   tx_data         registered framed word to lvds_trx
//   busy            high while the framer is not IDLE
//   level           current FIFO occupancy (0..DEPTH)
//   underrun        sticky, set when a sample was due but the FIFO was empty
//   clear_underrun  synchronous clear of underrun (a same-cycle set wins)
//   cw_mode         (only with IQ_FRAME_CW_EN) replace every sample with the
//                   constant I=Q=13'h0FFF; FIFO behaviour is unchanged
//
// Build option:
//   IQ_FRAME_CW_EN  when defined, adds the cw_mode input.
//
// Word formats:
//   SAMPLE = {2'b10, I[12:0], 1'b1, 2'b01, Q[12:0], 1'b0}
//   END    = {2'b10, 14'b0,   2'b01, 14'b0}
//   FILL   = 32'b0
// -----------------------------------------------------------------------------
module iq_frame_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [12:0]           s_i,
  input  logic [12:0]           s_q,
  input  logic                  s_last,
  input  logic                  word_req,
  output logic [31:0]           tx_data,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  input  logic                  clear_underrun
`ifdef IQ_FRAME_CW_EN
  ,
  input  logic                  cw_mode
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PREFILL_L = LVL_W'(PREFILL);

  localparam logic [31:0] FILL_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD  = {2'b10, 14'b0, 2'b01, 14'b0};

  // Constant sample used in continuous-wave mode.
  localparam logic [12:0] CW_SAMPLE = 13'h0FFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    TAIL   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_reg;
  logic [31:0]             tx_data_reg;
  logic                    underrun_reg;
  logic                    last_pending_reg;
  logic [LVL_W-1:0]        level_reg;
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]   rd_ptr_reg;

  // FIFO storage: each entry is {last, I, Q}.
  logic [26:0]             mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        underrun_set;
  logic        start_ok;
  logic [26:0] rd_entry;
  logic        rd_last;
  logic [12:0] word_i;
  logic [12:0] word_q;

  assign s_ready    = (level_reg < DEPTH_L);
  assign fifo_empty = (level_reg == '0);
  assign push       = s_valid & s_ready;

  // A pop only happens in STREAM on a word request with data available.
  // An empty FIFO never bypasses the incoming sample: that request takes
  // the underrun path and the same-cycle push is simply stored.
  assign pop          = (state_reg == STREAM) & word_req & ~fifo_empty;
  assign underrun_set = (state_reg == STREAM) & word_req &  fifo_empty;

  // Start streaming on a full prefill, or early when a whole (short)
  // message is already queued so its tail is not stranded.
  assign start_ok = (level_reg >= PREFILL_L) | last_pending_reg;

  assign rd_entry = mem[rd_ptr_reg];
  assign rd_last  = rd_entry[26];

`ifdef IQ_FRAME_CW_EN
  assign word_i = cw_mode ? CW_SAMPLE : rd_entry[25:13];
  assign word_q = cw_mode ? CW_SAMPLE : rd_entry[12:0];
`else
  assign word_i = rd_entry[25:13];
  assign word_q = rd_entry[12:0];
`endif

  function automatic logic [31:0] sample_word(input logic [12:0] i_val,
                                              input logic [12:0] q_val);
    return {2'b10, i_val, 1'b1, 2'b01, q_val, 1'b0};
  endfunction

  // Storage has no reset: contents are only ever read behind a valid level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {s_last, s_i, s_q};
    end
  end

  // Pointers, occupancy and the pending-last flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      last_pending_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase

      // A freshly pushed last outranks the clear from popping an older one,
      // so a queued message end is never forgotten.
      if (push && s_last) begin
        last_pending_reg <= 1'b1;
      end else if (pop && rd_last) begin
        last_pending_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Framer state machine with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_data_reg  <= FILL_WORD;
      underrun_reg <= 1'b0;
    end else begin
      // Set has priority over a same-cycle clear.
      if (underrun_set) begin
        underrun_reg <= 1'b1;
      end else if (clear_underrun) begin
        underrun_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (word_req) begin
            tx_data_reg <= FILL_WORD;
          end
          // Start condition is checked every cycle, not only on requests.
          if (start_ok) begin
            state_reg <= STREAM;
          end
        end

        STREAM: begin
          if (word_req) begin
            if (fifo_empty) begin
              tx_data_reg <= FILL_WORD;
            end else begin
              tx_data_reg <= sample_word(word_i, word_q);
              if (rd_last) begin
                state_reg <= TAIL;
              end
            end
          end
        end

        TAIL: begin
          if (word_req) begin
            tx_data_reg <= END_WORD;
            state_reg   <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_reg;
  assign busy     = (state_reg != IDLE);
  assign level    = level_reg;
  assign underrun = underrun_reg;

endmodule
